// File: rtl/perip_bus_arbiter.sv
// Two-master peripheral bus arbiter: fixed priority to port 0, a starvation guard for
// port 1, single-cycle writes and fixed-latency reads with data routed back to the owner.
module perip_bus_arbiter #(
  parameter int RD_LATENCY  = 2,
  parameter int M1_MAX_WAIT = 8
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_wen,
  input  logic [1:0]  m0_mask,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_wen,
  input  logic [1:0]  m1_mask,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] s_addr,
  output logic        s_wen,
  output logic [1:0]  s_mask,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata
);

  localparam int LW = $clog2(RD_LATENCY) + 1;
  localparam int WW = $clog2(M1_MAX_WAIT + 1);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t        state, state_next;
  logic [LW-1:0] lat_cnt, lat_next;
  logic [WW-1:0] wait_cnt, wait_next;
  logic          owner, owner_next;
  logic          grant_any, winner;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      wait_cnt <= '0;
      owner    <= 1'b0;
    end else begin
      state    <= state_next;
      lat_cnt  <= lat_next;
      wait_cnt <= wait_next;
      owner    <= owner_next;
    end
  end

  // Outputs are gated during reset so a held request or a pending read cannot leak out.
  always_comb begin
    state_next = state;
    lat_next   = lat_cnt;
    owner_next = owner;
    wait_next  = wait_cnt;
    grant_any  = 1'b0;
    winner     = 1'b0;
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    s_addr     = '0;
    s_wen      = 1'b0;
    s_mask     = 2'b10;
    s_wdata    = '0;

    if (!cpu_rst) begin
      case (state)
        IDLE: begin
          grant_any = m0_req | m1_req;
          if (m0_req && m1_req) begin
            winner = (wait_cnt == WW'(M1_MAX_WAIT));
          end else begin
            winner = m1_req;
          end
          if (grant_any) begin
            m0_gnt  = !winner;
            m1_gnt  = winner;
            s_addr  = winner ? m1_addr  : m0_addr;
            s_wen   = winner ? m1_wen   : m0_wen;
            s_mask  = winner ? m1_mask  : m0_mask;
            s_wdata = winner ? m1_wdata : m0_wdata;
            if (!s_wen) begin
              owner_next = winner;
              lat_next   = LW'(RD_LATENCY - 1);
              state_next = RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (lat_cnt != '0) begin
            lat_next = lat_cnt - LW'(1);
          end else begin
            m0_rvalid  = !owner;
            m1_rvalid  = owner;
            m0_rdata   = owner ? 32'h0 : s_rdata;
            m1_rdata   = owner ? s_rdata : 32'h0;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase

      // Port 1's wait counter also advances while a read blocks the bus.
      if (m1_gnt) begin
        wait_next = '0;
      end else if (m1_req && (wait_cnt != WW'(M1_MAX_WAIT))) begin
        wait_next = wait_cnt + WW'(1);
      end
    end
  end

endmodule
